moore_seq_detector: RTL and testbench

//   Parametrised Moore-type serial sequence detector: generalises the fixed 3-bit
//   "101" detector to any pattern of SEQ_LEN bits. Adds overlap/non-overlap mode,
//   an input qualifier and a saturating match counter.

---
 rtl/moore_seq_detector.sv | 131 +++++++++++++
 tb/tb_moore_seq_detector.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_detector.sv
// rtl/moore_seq_detector.sv - parametrised Moore serial sequence detector
// KMP transition tables are folded to constants at elaboration; runtime logic is a state/counter register pair.
module moore_seq_detector #(
   parameter int          SEQ_LEN = 3,
   parameter logic [15:0] PATTERN = 16'b101,
   parameter bit          OVERLAP = 1'b1,
   parameter int          CNT_W   = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           x,
   input  logic                           x_valid,
   input  logic                           count_clear,
   output logic                           z,
   output logic [CNT_W-1:0]               match_count,
   output logic [$clog2(SEQ_LEN+1)-1:0]   state
);

   localparam int               ST_W    = $clog2(SEQ_LEN + 1);
   localparam int               N_ST    = 1 << ST_W;
   localparam logic [ST_W-1:0]  DETECT  = ST_W'(SEQ_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (SEQ_LEN < 2 || SEQ_LEN > 16) begin : g_bad_len
      $error("moore_seq_detector: SEQ_LEN must be 2..16");
   end
   if ((PATTERN >> SEQ_LEN) != 16'd0) begin : g_bad_pattern
      $error("moore_seq_detector: PATTERN wider than SEQ_LEN");
   end

   // Bit i of the sequence in arrival order (i = 0 is received first).
   function automatic logic seq_bit(input int i);
      logic [15:0] p;
      p = PATTERN >> (SEQ_LEN - 1 - i);
      return p[0];
   endfunction

   function automatic int fail_len();
      int   best;
      logic ok;
      best = 0;
      for (int j = 1; j < 16; j++) begin
         if (j < SEQ_LEN) begin
            ok = 1'b1;
            for (int i = 0; i < 16; i++) begin
               if (i < j && seq_bit(i) != seq_bit(SEQ_LEN - j + i)) ok = 1'b0;
            end
            if (ok) best = j;
         end
      end
      return best;
   endfunction

   // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
   function automatic int kmp_next(input int k, input logic b);
      logic [16:0] s;
      logic [16:0] t;
      int          best;
      logic        ok;
      s = '0;
      for (int i = 0; i < 16; i++) begin
         if (i < k) s = s | (17'(seq_bit(i)) << i);
      end
      s = s | (17'(b) << k);
      best = 0;
      for (int j = 1; j <= 16; j++) begin
         if (j <= k + 1 && j <= SEQ_LEN) begin
            ok = 1'b1;
            for (int i = 0; i < 16; i++) begin
               t = s >> (k + 1 - j + i);
               if (i < j && t[0] != seq_bit(i)) ok = 1'b0;
            end
            if (ok) best = j;
         end
      end
      return best;
   endfunction

   localparam int BASE = OVERLAP ? fail_len() : 0;

   logic [ST_W-1:0] nxt0 [N_ST];
   logic [ST_W-1:0] nxt1 [N_ST];

   for (genvar g = 0; g < N_ST; g++) begin : g_tbl
      if (g <= SEQ_LEN) begin : g_live
         // DETECT restarts from the failure state (overlap) or from S0.
         localparam int              FROM = (g == SEQ_LEN) ? BASE : g;
         localparam logic [ST_W-1:0] N0   = ST_W'(kmp_next(FROM, 1'b0));
         localparam logic [ST_W-1:0] N1   = ST_W'(kmp_next(FROM, 1'b1));
         assign nxt0[g] = N0;
         assign nxt1[g] = N1;
      end else begin : g_dead
         assign nxt0[g] = '0;
         assign nxt1[g] = '0;
      end
   end

   logic [ST_W-1:0]  state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             enter_detect;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      enter_detect = 1'b0;
      if (x_valid) begin
         state_d      = x ? nxt1[state_q] : nxt0[state_q];
         enter_detect = (state_d == DETECT);
      end
      if (count_clear) begin
         cnt_d = enter_detect ? CNT_W'(1) : '0;
      end else if (enter_detect && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign z           = (state_q == DETECT);
   assign match_count = cnt_q;
   assign state       = state_q;

endmodule

// File: tb/tb_moore_seq_detector.sv
// tb/tb_moore_seq_detector.sv - scoreboard bench over four parameter sets of moore_seq_detector
module tb_moore_seq_detector;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic x = 1'b0, xv = 1'b0, clr = 1'b0;

   logic       z0, z1, z2, z3;
   logic [7:0] c0, c1, c2;
   logic [1:0] c3;
   logic [1:0] s0, s1, s3;
   logic [2:0] s2;

   always #5 clk = ~clk;

   moore_seq_detector u0 (.clk(clk), .reset(rst_n), .x(x), .x_valid(xv), .count_clear(clr),
                          .z(z0), .match_count(c0), .state(s0));
   moore_seq_detector #(.OVERLAP(1'b0)) u1 (.clk(clk), .reset(rst_n), .x(x), .x_valid(xv),
                          .count_clear(clr), .z(z1), .match_count(c1), .state(s1));
   moore_seq_detector #(.SEQ_LEN(4), .PATTERN(16'b1101)) u2 (.clk(clk), .reset(rst_n), .x(x),
                          .x_valid(xv), .count_clear(clr), .z(z2), .match_count(c2), .state(s2));
   moore_seq_detector #(.CNT_W(2)) u3 (.clk(clk), .reset(rst_n), .x(x), .x_valid(xv),
                          .count_clear(clr), .z(z3), .match_count(c3), .state(s3));

   logic [7:0] act_st [4];
   logic [7:0] act_cnt [4];
   logic [3:0] act_z;
   assign act_st[0] = 8'(s0);
   assign act_st[1] = 8'(s1);
   assign act_st[2] = 8'(s2);
   assign act_st[3] = 8'(s3);
   assign act_cnt[0] = c0;
   assign act_cnt[1] = c1;
   assign act_cnt[2] = c2;
   assign act_cnt[3] = 8'(c3);
   assign act_z = {z3, z2, z1, z0};

   typedef struct packed {
      logic [3:0][7:0] st;
      logic [3:0]      z;
      logic [3:0][7:0] cnt;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int checks = 0;
   int failures = 0;

   int          cfg_len [4] = '{3, 3, 4, 3};
   logic [15:0] cfg_pat [4] = '{16'b101, 16'b101, 16'b1101, 16'b101};
   bit          cfg_ovl [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   int          cfg_max [4] = '{255, 255, 255, 3};

   logic [31:0] m_hist [4];
   int          m_len [4];
   int          m_st [4];
   int          m_cnt [4];

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_hist[i] = '0;
         m_len[i] = 0;
         m_st[i] = 0;
         m_cnt[i] = 0;
      end
   endtask

   // Brute-force reference: longest pattern prefix equal to the tail of the accepted history.
   task automatic model_step(input logic xb, input logic v, input logic c, output exp_t e);
      int best;
      bit match;
      logic [31:0] mask;
      logic [15:0] pp;
      for (int i = 0; i < 4; i++) begin
         match = 1'b0;
         if (v) begin
            m_hist[i] = {m_hist[i][30:0], xb};
            if (m_len[i] < 32) m_len[i]++;
            best = 0;
            for (int j = 1; j <= cfg_len[i]; j++) begin
               if (j <= m_len[i]) begin
                  mask = (32'h1 << j) - 32'h1;
                  pp = cfg_pat[i] >> (cfg_len[i] - j);
                  if ((m_hist[i] & mask) == 32'(pp)) best = j;
               end
            end
            m_st[i] = best;
            if (best == cfg_len[i]) begin
               match = 1'b1;
               if (!cfg_ovl[i]) m_len[i] = 0;
            end
         end
         if (c) m_cnt[i] = match ? 1 : 0;
         else if (match && m_cnt[i] < cfg_max[i]) m_cnt[i]++;
         e.st[i] = 8'(m_st[i]);
         e.z[i] = (m_st[i] == cfg_len[i]);
         e.cnt[i] = 8'(m_cnt[i]);
      end
   endtask

   task automatic apply(input logic xb, input logic v, input logic c);
      exp_t e;
      x = xb;
      xv = v;
      clr = c;
      model_step(xb, v, c, e);
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      if (q.size() != 0) begin
         mon_e = q.pop_front();
         #2;
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (act_st[i] !== mon_e.st[i] || act_z[i] !== mon_e.z[i] || act_cnt[i] !== mon_e.cnt[i]) begin
               failures++;
               $display("FAIL sb_u%0d t=%0t got state=%0d z=%0b count=%0d want state=%0d z=%0b count=%0d",
                        i, $time, act_st[i], act_z[i], act_cnt[i], mon_e.st[i], mon_e.z[i], mon_e.cnt[i]);
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      x = 1'b0;
      xv = 1'b0;
      clr = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (act_st[i] !== 8'd0 || act_z[i] !== 1'b0 || act_cnt[i] !== 8'd0) begin
            failures++;
            $display("FAIL reset_u%0d got state=%0d z=%0b count=%0d want 0/0/0", i, act_st[i], act_z[i], act_cnt[i]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_overlap();
      logic [4:0] bits = 5'b10101;
      do_reset();
      for (int i = 4; i >= 0; i--) apply(bits[i], 1'b1, 1'b0);
      checks++;
      if (c0 !== 8'd2) begin
         failures++;
         $display("FAIL overlap_count got=%0d want=2", c0);
      end
      checks++;
      if (c1 !== 8'd1) begin
         failures++;
         $display("FAIL nonoverlap_count got=%0d want=1", c1);
      end
   endtask

   task automatic test_pattern4();
      logic [4:0] bits = 5'b11101;
      do_reset();
      for (int i = 4; i >= 0; i--) apply(bits[i], 1'b1, 1'b0);
      checks++;
      if (s2 !== 3'd4 || z2 !== 1'b1 || c2 !== 8'd1) begin
         failures++;
         $display("FAIL pattern4 got state=%0d z=%0b count=%0d want 4/1/1", s2, z2, c2);
      end
   endtask

   task automatic test_stall();
      do_reset();
      apply(1'b1, 1'b1, 1'b0);
      apply(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) apply(i[0], 1'b0, 1'b0);
      checks++;
      if (s0 !== 2'd2 || z0 !== 1'b0) begin
         failures++;
         $display("FAIL stall_hold got state=%0d z=%0b want 2/0", s0, z0);
      end
      apply(1'b1, 1'b1, 1'b0);
      checks++;
      if (z0 !== 1'b1 || c0 !== 8'd1) begin
         failures++;
         $display("FAIL stall_resume got z=%0b count=%0d want 1/1", z0, c0);
      end
   endtask

   task automatic test_async_reset();
      logic [4:0] bits = 5'b10110;
      do_reset();
      for (int i = 4; i >= 0; i--) apply(bits[i], 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (s0 !== 2'd0 || z0 !== 1'b0 || c0 !== 8'd0) begin
         failures++;
         $display("FAIL async_reset got state=%0d z=%0b count=%0d want 0/0/0", s0, z0, c0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      apply(1'b1, 1'b1, 1'b0);
      apply(1'b0, 1'b1, 1'b0);
      apply(1'b1, 1'b1, 1'b0);
      checks++;
      if (z0 !== 1'b1 || c0 !== 8'd1) begin
         failures++;
         $display("FAIL after_reset got z=%0b count=%0d want 1/1", z0, c0);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      apply(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         apply(1'b0, 1'b1, 1'b0);
         apply(1'b1, 1'b1, 1'b0);
      end
      checks++;
      if (c3 !== 2'd3 || c0 !== 8'd5) begin
         failures++;
         $display("FAIL saturate got c3=%0d c0=%0d want 3/5", c3, c0);
      end
      apply(1'b0, 1'b1, 1'b0);
      apply(1'b1, 1'b1, 1'b1);
      checks++;
      if (c3 !== 2'd1 || c0 !== 8'd1) begin
         failures++;
         $display("FAIL clear_on_match got c3=%0d c0=%0d want 1/1", c3, c0);
      end
      apply(1'b0, 1'b1, 1'b1);
      checks++;
      if (c3 !== 2'd0 || z3 !== 1'b0) begin
         failures++;
         $display("FAIL clear_plain got c3=%0d z3=%0b want 0/0", c3, z3);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 1000; i++)
         apply(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0));
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_pattern4();
      test_stall();
      test_async_reset();
      test_saturate();
      test_random();
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
